// File: rtl/mac_col_sequencer_pkg.sv
// Shared definitions for the MAC column issue sequencer: FSM state
// encoding and the default width of the K depth configuration.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int unsigned KW_DEF = 8;

endpackage

// File: rtl/mac_col_sequencer_idx_cnt.sv
// Nested (col, k) index counter: k runs fastest and wraps at k_max, then col
// advances. Supports clear, parallel load and increment, and flags the final
// (col = SIZE-1, k = k_max) position.
module mac_seq_idx_cnt
  import mac_pkg::*;
#(
  parameter int unsigned SIZE = 16,
  parameter int unsigned KW   = KW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [KW-1:0]           k_max,
  input  logic                    clr,
  input  logic                    load,
  input  logic [$clog2(SIZE)-1:0] load_col,
  input  logic [KW-1:0]           load_k,
  input  logic                    inc,
  output logic [$clog2(SIZE)-1:0] col,
  output logic [KW-1:0]           k,
  output logic                    last
);

  localparam int unsigned COL_W = $clog2(SIZE);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(SIZE - 1);

  // Index register: clear wins over load, load wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      k   <= '0;
    end else if (clr) begin
      col <= '0;
      k   <= '0;
    end else if (load) begin
      col <= load_col;
      k   <= load_k;
    end else if (inc) begin
      if (k == k_max) begin
        k   <= '0;
        col <= (col == COL_MAX) ? '0 : col + 1'b1;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  // Final position of the walk.
  always_comb begin
    last = (col == COL_MAX) && (k == k_max);
  end

endmodule

// File: rtl/mac_col_sequencer.sv
// Issue controller for the FP multiply column. Walks every (B column, k)
// pair, issues A/B buffer reads and drives the column tag inputs one cycle
// later, aligned with the buffer read data. A stall flushes the column, so
// the issue position is rewound to the first uncommitted item and replayed.
// Optional build macro: MAC_SEQ_PERF_CNT_EN adds perf_cycles/perf_replays.
module mac_col_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned SIZE    = 16,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned KW      = KW_DEF,
  parameter int unsigned ADDR_W  = $clog2(SIZE) + KW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KW-1:0]           cfg_k,
  output logic                    busy,
  output logic                    job_done,
  input  logic                    stall,
  output logic                    a_rd_en,
  output logic [KW-1:0]           a_rd_addr,
  output logic                    b_rd_en,
  output logic [ADDR_W-1:0]       b_rd_addr,
  output logic                    valid_pipe_in,
  output logic [$clog2(SIZE)-1:0] b_col_pipe_in,
  output logic                    new_pipe_in,
  output logic                    done_pipe_in,
  input  logic                    valid_pipe_out,
  input  logic                    done_pipe_out
`ifdef MAC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]             perf_cycles,
  output logic [15:0]             perf_replays
`endif
);

  localparam int unsigned COL_W = $clog2(SIZE);
  // Pipeline depth is only descriptive: replay rewinds to the commit point.
  localparam int unsigned unused_latency = LATENCY;

  seq_state_t state_q, state_d;

  logic [KW-1:0]    k_lim_q;
  logic [KW-1:0]    k_max;
  logic             job_start;
  logic             issue_fire;
  logic             commit_fire;
  logic             stall_act;

  logic [COL_W-1:0] issue_col, commit_col;
  logic [KW-1:0]    issue_k, commit_k;
  logic             issue_last;
  logic             unused_commit_last;

  assign k_max = k_lim_q - 1'b1;

  // Issue position; rewound to the commit position on every stall cycle.
  mac_seq_idx_cnt #(
    .SIZE (SIZE),
    .KW   (KW)
  ) u_issue_cnt (
    .clk      (clk),
    .rst      (rst),
    .k_max    (k_max),
    .clr      (job_start),
    .load     (stall_act),
    .load_col (commit_col),
    .load_k   (commit_k),
    .inc      (issue_fire),
    .col      (issue_col),
    .k        (issue_k),
    .last     (issue_last)
  );

  // Commit position: first item whose result has not yet retired.
  mac_seq_idx_cnt #(
    .SIZE (SIZE),
    .KW   (KW)
  ) u_commit_cnt (
    .clk      (clk),
    .rst      (rst),
    .k_max    (k_max),
    .clr      (job_start),
    .load     (1'b0),
    .load_col ('0),
    .load_k   ('0),
    .inc      (commit_fire),
    .col      (commit_col),
    .k        (commit_k),
    .last     (unused_commit_last)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-cycle controls. Retirements seen during a stall are
  // void because the column flushes them, so commit only advances unstalled.
  always_comb begin
    state_d     = state_q;
    job_start   = 1'b0;
    issue_fire  = 1'b0;
    commit_fire = 1'b0;
    stall_act   = 1'b0;
    busy        = 1'b0;
    job_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          job_start = 1'b1;
          state_d   = (cfg_k == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (stall) begin
          stall_act = 1'b1;
        end else begin
          issue_fire  = 1'b1;
          commit_fire = valid_pipe_out;
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (stall) begin
          stall_act = 1'b1;
          state_d   = ISSUE;
        end else begin
          commit_fire = valid_pipe_out;
          if (done_pipe_out) state_d = DONE;
        end
      end
      DONE: begin
        busy     = 1'b1;
        job_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer read requests for the current issue position.
  always_comb begin
    a_rd_en   = issue_fire;
    b_rd_en   = issue_fire;
    a_rd_addr = issue_fire ? issue_k : '0;
    b_rd_addr = issue_fire ? ADDR_W'({issue_k, issue_col}) : '0;
  end

  // Latch the job depth when a job is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            k_lim_q <= '0;
    else if (job_start) k_lim_q <= cfg_k;
  end

  // Tags lag the read by one cycle to line up with buffer data; a stall
  // cycle issues nothing, which clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_pipe_in <= 1'b0;
      b_col_pipe_in <= '0;
      new_pipe_in   <= 1'b0;
      done_pipe_in  <= 1'b0;
    end else begin
      valid_pipe_in <= issue_fire;
      b_col_pipe_in <= issue_fire ? issue_col : '0;
      new_pipe_in   <= issue_fire && (issue_k == '0);
      done_pipe_in  <= issue_fire && issue_last;
    end
  end

`ifdef MAC_SEQ_PERF_CNT_EN
  logic in_flight;

  // In DRAIN the issue counter has wrapped, so compare positions only in ISSUE.
  always_comb begin
    in_flight = (state_q == DRAIN) ||
                (issue_col != commit_col) || (issue_k != commit_k);
  end

  // Saturating busy-cycle and replay counters, cleared on job acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles  <= '0;
      perf_replays <= '0;
    end else if (job_start) begin
      perf_cycles  <= '0;
      perf_replays <= '0;
    end else begin
      if (busy && (perf_cycles != '1))
        perf_cycles <= perf_cycles + 1'b1;
      if (stall_act && in_flight && (perf_replays != '1))
        perf_replays <= perf_replays + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_col_sequencer.sv
// Directed bench for mac_col_sequencer (SIZE=4, K=3) with a 3-stage model of
// the multiply column that flushes on stall and tracks retired item order.
module tb_mac_col_sequencer;

  localparam int unsigned SIZE   = 4;
  localparam int unsigned KW     = 8;
  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [KW-1:0]     cfg_k;
  logic              busy, job_done, stall;
  logic              a_rd_en, b_rd_en;
  logic [KW-1:0]     a_rd_addr;
  logic [ADDR_W-1:0] b_rd_addr;
  logic              valid_pipe_in, new_pipe_in, done_pipe_in;
  logic [1:0]        b_col_pipe_in;
  logic              valid_pipe_out, done_pipe_out;
`ifdef MAC_SEQ_PERF_CNT_EN
  logic [31:0]       perf_cycles;
  logic [15:0]       perf_replays;
`endif

  mac_col_sequencer #(
    .SIZE    (SIZE),
    .LATENCY (3),
    .KW      (KW),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_k          (cfg_k),
    .busy           (busy),
    .job_done       (job_done),
    .stall          (stall),
    .a_rd_en        (a_rd_en),
    .a_rd_addr      (a_rd_addr),
    .b_rd_en        (b_rd_en),
    .b_rd_addr      (b_rd_addr),
    .valid_pipe_in  (valid_pipe_in),
    .b_col_pipe_in  (b_col_pipe_in),
    .new_pipe_in    (new_pipe_in),
    .done_pipe_in   (done_pipe_in),
    .valid_pipe_out (valid_pipe_out),
    .done_pipe_out  (done_pipe_out)
`ifdef MAC_SEQ_PERF_CNT_EN
    ,
    .perf_cycles    (perf_cycles),
    .perf_replays   (perf_replays)
`endif
  );

  always #5 clk = ~clk;

  // Column model: 3 stages, flushed by stall, output zeroed while stalled.
  logic [2:0] p_v = '0;
  logic [2:0] p_d = '0;
  int         p_id [3];
  int         rd_id = 0;
  int         exp_id = 0;
  int         rd_cnt = 0;
  int         retire_cnt = 0;
  int         order_err = 0;
  int         jd_cnt = 0;

  assign valid_pipe_out = p_v[2] & ~stall;
  assign done_pipe_out  = p_d[2] & ~stall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_v    <= '0;
      p_d    <= '0;
      exp_id <= 0;
    end else begin
      if (b_rd_en) rd_id <= int'(b_rd_addr[1:0]) * 3 + int'(b_rd_addr[9:2]);
      if (stall) begin
        p_v <= '0;
        p_d <= '0;
      end else begin
        p_v     <= {p_v[1:0], valid_pipe_in};
        p_d     <= {p_d[1:0], done_pipe_in};
        p_id[0] <= rd_id;
        p_id[1] <= p_id[0];
        p_id[2] <= p_id[1];
      end
      if (start && !busy) exp_id <= 0;
      if (valid_pipe_out) begin
        retire_cnt <= retire_cnt + 1;
        if (p_id[2] != exp_id) order_err <= order_err + 1;
        exp_id <= exp_id + 1;
      end
      if (a_rd_en)  rd_cnt <= rd_cnt + 1;
      if (job_done) jd_cnt <= jd_cnt + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  int rd0, rt0, jd0, oe0, first_jd;

  task automatic snap();
    rd0 = rd_cnt; rt0 = retire_cnt; jd0 = jd_cnt; oe0 = order_err;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; cfg_k = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_job_done", job_done, 0);
    chk("rst_a_rd_en", a_rd_en, 0);
    chk("rst_valid_in", valid_pipe_in, 0);
    rst = 1'b0;
    @(negedge clk);

    // Job 1: no stall, full cycle-by-cycle check.
    snap();
    cfg_k = 8'd3; start = 1'b1;
    for (int cy = 1; cy <= 18; cy++) begin
      @(negedge clk); start = 1'b0; #1;
      begin
        int i, t;
        bit rd, tg;
        i = cy - 1; t = cy - 2;
        rd = (cy <= 12); tg = (cy >= 2) && (cy <= 13);
        chk("j1_a_rd_en", a_rd_en, int'(rd));
        chk("j1_b_rd_en", b_rd_en, int'(rd));
        chk("j1_a_addr", a_rd_addr, rd ? i % 3 : 0);
        chk("j1_b_addr", b_rd_addr, rd ? (i % 3) * 4 + i / 3 : 0);
        chk("j1_valid_in", valid_pipe_in, int'(tg));
        chk("j1_new_in", new_pipe_in, int'(tg && (t % 3 == 0)));
        chk("j1_done_in", done_pipe_in, int'(cy == 13));
        chk("j1_bcol_in", b_col_pipe_in, tg ? t / 3 : 0);
        chk("j1_busy", busy, int'(cy <= 17));
        chk("j1_job_done", job_done, int'(cy == 17));
      end
    end
    chk("j1_reads", rd_cnt - rd0, 12);
    chk("j1_retires", retire_cnt - rt0, 12);
    chk("j1_order", order_err - oe0, 0);
    chk("j1_done_cnt", jd_cnt - jd0, 1);

    // Job 2: stall cycles 7-8 after two commits; replay from item 2.
    @(negedge clk);
    snap();
    start = 1'b1;
    for (int cy = 1; cy <= 24; cy++) begin
      @(negedge clk); start = 1'b0;
      stall = (cy == 7) || (cy == 8);
      #1;
      if (cy == 7) chk("j2_commits_before_stall", retire_cnt - rt0, 2);
      if (cy == 7 || cy == 8) chk("j2_stall_no_read", a_rd_en, 0);
      if (cy == 9) begin
        chk("j2_replay_en", a_rd_en, 1);
        chk("j2_replay_addr", b_rd_addr, 8);
      end
      if (cy == 22) chk("j2_no_early_done", job_done, 0);
      if (cy == 23) chk("j2_job_done", job_done, 1);
    end
    chk("j2_reads", rd_cnt - rd0, 16);
    chk("j2_retires", retire_cnt - rt0, 12);
    chk("j2_order", order_err - oe0, 0);
    chk("j2_done_cnt", jd_cnt - jd0, 1);
`ifdef MAC_SEQ_PERF_CNT_EN
    chk("j2_perf_replays", perf_replays, 1);
    chk("j2_perf_cycles", perf_cycles, 23);
`endif

    // Job 3: K = 0 completes immediately with no reads.
    @(negedge clk);
    snap();
    cfg_k = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    chk("k0_busy", busy, 1);
    chk("k0_job_done", job_done, 1);
    chk("k0_no_read", a_rd_en, 0);
    @(negedge clk); #1;
    chk("k0_busy_after", busy, 0);
    chk("k0_job_done_after", job_done, 0);
    chk("k0_reads", rd_cnt - rd0, 0);
    chk("k0_done_cnt", jd_cnt - jd0, 1);

    // Job 4: start (with different K) while busy is ignored.
    @(negedge clk);
    snap();
    cfg_k = 8'd3; start = 1'b1; first_jd = -1;
    for (int cy = 1; cy <= 40; cy++) begin
      @(negedge clk);
      start = (cy == 5);
      cfg_k = (cy == 5) ? 8'd1 : 8'd3;
      #1;
      if (job_done && first_jd < 0) first_jd = cy;
    end
    start = 1'b0; cfg_k = 8'd3;
    chk("busy_start_done_cycle", first_jd, 17);
    chk("busy_start_done_cnt", jd_cnt - jd0, 1);
    chk("busy_start_reads", rd_cnt - rd0, 12);

    // Job 5: async reset mid-ISSUE, then a clean job.
    @(negedge clk);
    snap();
    start = 1'b1;
    for (int cy = 1; cy <= 4; cy++) begin
      @(negedge clk); start = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_a_rd_en", a_rd_en, 0);
    chk("arst_b_rd_en", b_rd_en, 0);
    chk("arst_b_addr", b_rd_addr, 0);
    chk("arst_a_addr", a_rd_addr, 0);
    chk("arst_valid_in", valid_pipe_in, 0);
    chk("arst_new_in", new_pipe_in, 0);
    chk("arst_done_in", done_pipe_in, 0);
    chk("arst_bcol_in", b_col_pipe_in, 0);
    chk("arst_job_done", job_done, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("arst_no_job_done", jd_cnt - jd0, 0);
    snap();
    start = 1'b1;
    for (int cy = 1; cy <= 18; cy++) begin
      @(negedge clk); start = 1'b0; #1;
      if (cy == 1) begin
        chk("arst_restart_en", a_rd_en, 1);
        chk("arst_restart_addr", b_rd_addr, 0);
      end
      if (cy == 2) begin
        chk("arst_restart_valid", valid_pipe_in, 1);
        chk("arst_restart_new", new_pipe_in, 1);
      end
      if (cy == 17) chk("arst_restart_job_done", job_done, 1);
    end
    chk("arst_restart_retires", retire_cnt - rt0, 12);
    chk("arst_restart_order", order_err - oe0, 0);
    chk("arst_restart_done_cnt", jd_cnt - jd0, 1);

    // Job 6: stall exactly when done would retire in DRAIN.
    @(negedge clk);
    snap();
    start = 1'b1;
    for (int cy = 1; cy <= 23; cy++) begin
      @(negedge clk); start = 1'b0;
      stall = (cy == 16);
      #1;
      if (cy == 16) begin
        chk("drain_stall_no_read", a_rd_en, 0);
        chk("drain_stall_no_done", job_done, 0);
      end
      if (cy == 17) begin
        chk("drain_replay_en", a_rd_en, 1);
        chk("drain_replay_addr", b_rd_addr, 11);
        chk("drain_replay_done_tag_next", busy, 1);
      end
      if (cy == 21) chk("drain_no_early_done", jd_cnt - jd0, 0);
      if (cy == 22) chk("drain_job_done", job_done, 1);
    end
    chk("drain_reads", rd_cnt - rd0, 13);
    chk("drain_retires", retire_cnt - rt0, 12);
    chk("drain_order", order_err - oe0, 0);
    chk("drain_done_cnt", jd_cnt - jd0, 1);
`ifdef MAC_SEQ_PERF_CNT_EN
    chk("drain_perf_replays", perf_replays, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
